// File: rtl/inst_prefetch_buf.sv
// ---------------------------------------------------------------------------
// inst_prefetch_buf
// Instruction-fetch front end sitting between the instruction memory bus and
// the IF/ID pipeline register. It issues sequential single-outstanding word
// fetches on a variable-latency req/ack bus and buffers the returned words
// with their PCs in a small FIFO. The FIFO feeds IF/ID under valid/stall flow
// control. A flush discards buffered and in-flight fetches and redirects the
// fetch stream.
//
// Optional build macro: FETCH_BYPASS_EN
//   When defined, a word returning into an empty FIFO is presented to IF/ID
//   combinationally in the ack cycle. It is only written into the FIFO if
//   IF/ID stalls in that cycle.
// ---------------------------------------------------------------------------
module inst_prefetch_buf #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        bus_req_o,
    output logic [31:0] bus_addr_o,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_data_i,
    input  logic        flush_i,
    input  logic [31:0] flush_pc_i,
    input  logic        stall_i,
    output logic        if_valid_o,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_inst_o
);

    // Pointer width and count width; the count needs one extra bit so it
    // can represent a completely full FIFO.
    localparam int             AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int             CW      = AW + 1;
    localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    // Force a byte address onto a word boundary.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    // State and datapath registers
    state_t        r_state;
    logic          r_bus_req;
    logic [31:0]   r_bus_addr;
    logic [31:0]   r_fetch_pc;
    logic [CW-1:0] r_count;
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [31:0]   r_mem_pc   [DEPTH];
    logic [31:0]   r_mem_inst [DEPTH];

    // Combinational next-state and control
    state_t        w_state_next;
    logic [31:0]   w_fetch_pc_next;
    logic [31:0]   w_bus_addr_next;
    logic          w_bus_req_next;
    logic [CW-1:0] w_count_next;
    logic          w_ack_req;
    logic          w_push;
    logic          w_pop;
    logic          w_bypass;
    logic          w_fifo_empty;
    logic [31:0]   w_head_pc;
    logic [31:0]   w_head_inst;

    assign w_fifo_empty = (r_count == {CW{1'b0}});
    assign w_head_pc    = r_mem_pc[r_rd_ptr];
    assign w_head_inst  = r_mem_inst[r_rd_ptr];

    // A returned word that is kept: ack in REQ with no flush overriding it.
    // Data acked in DROP, or acked together with a flush, is discarded.
    assign w_ack_req = (r_state == ST_REQ) && bus_ack_i && !flush_i;

`ifdef FETCH_BYPASS_EN
    assign w_bypass = w_fifo_empty && w_ack_req;
`else
    assign w_bypass = 1'b0;
`endif

    // A bypassed word consumed by IF/ID in the same cycle never enters the FIFO.
    assign w_push = w_ack_req && !(w_bypass && !stall_i);
    // Only buffered entries are popped; flush overrides any pop.
    assign w_pop  = !w_fifo_empty && !stall_i && !flush_i;

    // Next FIFO occupancy: flush clears, otherwise push and pop cancel.
    always_comb begin
        w_count_next = r_count;
        if (flush_i) begin
            w_count_next = {CW{1'b0}};
        end else begin
            case ({w_push, w_pop})
                2'b10:   w_count_next = r_count + CW'(1);
                2'b01:   w_count_next = r_count - CW'(1);
                default: w_count_next = r_count;
            endcase
        end
    end

    // Fetch FSM next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!flush_i && (r_count < DEPTH_C)) begin
                    w_state_next = ST_REQ;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (flush_i) begin
                    // An ack coinciding with the flush completes the
                    // outstanding request, so nothing is left to drain.
                    if (bus_ack_i) begin
                        w_state_next = ST_IDLE;
                    end else begin
                        w_state_next = ST_DROP;
                    end
                end else if (bus_ack_i) begin
                    if (w_count_next < DEPTH_C) begin
                        w_state_next = ST_REQ;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end else begin
                    w_state_next = ST_REQ;
                end
            end
            ST_DROP: begin
                if (bus_ack_i) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_DROP;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Fetch pointer: redirect on flush, advance one word per kept ack.
    // The 32-bit add wraps 32'hFFFF_FFFC to 0.
    always_comb begin
        w_fetch_pc_next = r_fetch_pc;
        if (flush_i) begin
            w_fetch_pc_next = align_word(flush_pc_i);
        end else if ((r_state == ST_REQ) && bus_ack_i) begin
            w_fetch_pc_next = r_fetch_pc + 32'd4;
        end else begin
            w_fetch_pc_next = r_fetch_pc;
        end
    end

    // Bus address only loads when a REQ cycle follows; it is frozen in DROP
    // so the abandoned request stays stable until its ack.
    always_comb begin
        w_bus_addr_next = r_bus_addr;
        w_bus_req_next  = 1'b0;
        if (w_state_next == ST_REQ) begin
            w_bus_addr_next = w_fetch_pc_next;
            w_bus_req_next  = 1'b1;
        end else if (w_state_next == ST_DROP) begin
            w_bus_addr_next = r_bus_addr;
            w_bus_req_next  = 1'b1;
        end else begin
            w_bus_addr_next = r_bus_addr;
            w_bus_req_next  = 1'b0;
        end
    end

    // FSM state, fetch pointer and registered bus request/address.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_fetch_pc <= RESET_PC;
            r_bus_addr <= RESET_PC;
            r_bus_req  <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_fetch_pc <= w_fetch_pc_next;
            r_bus_addr <= w_bus_addr_next;
            r_bus_req  <= w_bus_req_next;
        end
    end

    // FIFO occupancy and pointers; a flush rewinds both pointers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count  <= {CW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_wr_ptr <= {AW{1'b0}};
        end else if (flush_i) begin
            r_count  <= {CW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_wr_ptr <= {AW{1'b0}};
        end else begin
            r_count <= w_count_next;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
        end
    end

    // FIFO storage: each entry holds the fetched word and its PC.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_pc[i]   <= 32'h0000_0000;
                r_mem_inst[i] <= 32'h0000_0000;
            end
        end else if (w_push) begin
            r_mem_pc[r_wr_ptr]   <= r_fetch_pc;
            r_mem_inst[r_wr_ptr] <= bus_data_i;
        end
    end

    // IF/ID presentation: FIFO head when buffered, the returning bus word
    // when bypassing, otherwise zeros.
    always_comb begin
        if_valid_o = 1'b0;
        if_pc_o    = 32'h0000_0000;
        if_inst_o  = 32'h0000_0000;
        if (!w_fifo_empty) begin
            if_valid_o = 1'b1;
            if_pc_o    = w_head_pc;
            if_inst_o  = w_head_inst;
        end else if (w_bypass) begin
            if_valid_o = 1'b1;
            if_pc_o    = r_fetch_pc;
            if_inst_o  = bus_data_i;
        end else begin
            if_valid_o = 1'b0;
            if_pc_o    = 32'h0000_0000;
            if_inst_o  = 32'h0000_0000;
        end
    end

    assign bus_req_o  = r_bus_req;
    assign bus_addr_o = r_bus_addr;

endmodule
